// File: rtl/note_sequencer.sv
// Record/playback note sequencer: captures notes on load_n release and replays
// them at a fixed step rate, with loop, stop, clear and empty-playback guard.
module note_sequencer #(
  parameter int NOTE_W         = 4,
  parameter int DEPTH          = 16,
  parameter int TICKS_PER_STEP = 25000000,
  localparam int CNT_W         = $clog2(DEPTH + 1),
  localparam int IDX_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_n,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              playback,
  input  logic              stop_n,
  input  logic              clear_n,
  input  logic              loop_en,
  output logic              ld_note,
  output logic              ld_play,
  output logic [NOTE_W-1:0] note_out,
  output logic [IDX_W-1:0]  note_idx,
  output logic [CNT_W-1:0]  notes_recorded,
  output logic              full,
  output logic              step_tick
);

  localparam int DIV_W = $clog2(TICKS_PER_STEP);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICKS_PER_STEP - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t             state;
  logic [DIV_W-1:0]   divider;
  logic [NOTE_W-1:0]  mem [DEPTH];
  logic               write_en;
  logic               last_note;

  assign full      = (notes_recorded == FULL_CNT);
  assign ld_note   = (state == LOAD);
  assign ld_play   = (state == PLAY);
  assign step_tick = ld_play && (divider == '0);
  assign write_en  = ld_note && load_n && !full;
  // Compare idx+1 against the count so an empty count can never underflow.
  assign last_note = (CNT_W'(note_idx) + CNT_W'(1)) >= notes_recorded;
  assign note_out  = ld_play ? mem[note_idx] : '0;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[notes_recorded[IDX_W-1:0]] <= note_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      notes_recorded <= '0;
      note_idx       <= '0;
      divider        <= DIV_RELOAD;
    end else begin
      case (state)
        IDLE: begin
          if (!load_n) begin
            state <= LOAD;
          end else if (!playback) begin
            if (notes_recorded != '0) begin
              state    <= PLAY;
              note_idx <= '0;
              divider  <= DIV_RELOAD;
            end
          end else if (!clear_n) begin
            notes_recorded <= '0;
          end
        end
        LOAD: begin
          if (load_n) begin
            if (!full) begin
              notes_recorded <= notes_recorded + CNT_W'(1);
            end
            state <= IDLE;
          end
        end
        PLAY: begin
          if (!stop_n) begin
            state    <= IDLE;
            note_idx <= '0;
          end else if (step_tick) begin
            divider <= DIV_RELOAD;
            if (!last_note) begin
              note_idx <= note_idx + IDX_W'(1);
            end else if (loop_en) begin
              note_idx <= '0;
            end else begin
              state    <= IDLE;
              note_idx <= '0;
            end
          end else begin
            divider <= divider - DIV_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          note_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: cycle model of record/playback rules plus directed
// scenarios with hand-computed note sequences.
module tb_note_sequencer;
  localparam int NW = 4;
  localparam int DP = 4;
  localparam int TK = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          load_n = 1, playback = 1, stop_n = 1, clear_n = 1, loop_en = 0;
  logic [NW-1:0] note_in = '0;
  logic          ld_note, ld_play, full, step_tick;
  logic [NW-1:0] note_out;
  logic [1:0]    note_idx;
  logic [2:0]    notes_recorded;

  int passed = 0;
  int total  = 0;
  int log_q[$];

  note_sequencer #(.NOTE_W(NW), .DEPTH(DP), .TICKS_PER_STEP(TK)) dut (
    .clk(clk), .reset(rst_n), .load_n(load_n), .note_in(note_in),
    .playback(playback), .stop_n(stop_n), .clear_n(clear_n), .loop_en(loop_en),
    .ld_note(ld_note), .ld_play(ld_play), .note_out(note_out), .note_idx(note_idx),
    .notes_recorded(notes_recorded), .full(full), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: 0 idle, 1 recording, 2 playing; elapsed counts cycles into current note.
  int m_mode, m_count, m_pos, m_elapsed;
  int m_mem[DP];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_count = 0; m_pos = 0; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: if (!load_n) m_mode = 1;
           else if (!playback) begin
             if (m_count > 0) begin m_mode = 2; m_pos = 0; m_elapsed = 0; end
           end else if (!clear_n) m_count = 0;
        1: if (load_n) begin
             if (m_count < DP) begin m_mem[m_count] = int'(note_in); m_count++; end
             m_mode = 0;
           end
        default: if (!stop_n) m_mode = 0;
           else if (m_elapsed == TK - 1) begin
             m_elapsed = 0;
             if (m_pos < m_count - 1) m_pos++;
             else if (loop_en) m_pos = 0;
             else m_mode = 0;
           end else m_elapsed++;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int e_out, e_idx;
      e_out = (m_mode == 2) ? m_mem[m_pos] : 0;
      e_idx = (m_mode == 2) ? m_pos : 0;
      check("cycle_outputs",
            int'({ld_note, ld_play, note_out, note_idx, notes_recorded, full, step_tick}),
            ((m_mode == 1) << 12) | ((m_mode == 2) << 11) | (e_out << 7) | (e_idx << 5) |
            (m_count << 2) | ((m_count == DP) << 1) | int'((m_mode == 2) && (m_elapsed == TK - 1)));
      if (ld_play) log_q.push_back(int'(note_out));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic record(int n);
    load_n = 0; note_in = NW'(n);
    tick(); tick();
    check("ld_note_held", int'(ld_note), 1);
    load_n = 1;
    tick();
  endtask

  task automatic start_play();
    log_q.delete();
    playback = 0; tick(); playback = 1;
  endtask

  task automatic wait_end();
    int n = 0;
    while (ld_play && n < 200) begin @(negedge clk); n++; end
    check("play_end_bound", int'(ld_play), 0);
    tick();
  endtask

  task automatic check_log(string name, int exp[$]);
    check({name, "_len"}, log_q.size(), exp.size());
    foreach (exp[i]) if (i < log_q.size()) check(name, log_q[i], exp[i]);
  endtask

  task automatic clear_all();
    clear_n = 0; tick(); clear_n = 1; tick();
    check("cleared", int'(notes_recorded), 0);
  endtask

  initial begin
    int n;
    int exp_a[$] = '{3,3,3,3, 5,5,5,5, 9,9,9,9};
    int exp_b[$] = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 4,4,4,4};
    int exp_c[$] = '{7,7,7,7, 2,2,2,2, 7,7,7,7, 2,2,2,2, 7,7,7,7};

    #12 rst_n = 1;
    tick();
    check("rst_ld_note", int'(ld_note), 0);
    check("rst_ld_play", int'(ld_play), 0);
    check("rst_count", int'(notes_recorded), 0);
    check("rst_note_out", int'(note_out), 0);
    check("rst_full", int'(full), 0);

    start_play(); tick();
    check("empty_play_idle", int'(ld_play), 0);

    record(3); check("ld_note_released", int'(ld_note), 0);
    record(5); record(9);
    check("count_3", int'(notes_recorded), 3);
    check("not_full", int'(full), 0);
    start_play(); wait_end();
    check_log("seq_359", exp_a);

    clear_all();
    record(1); record(2); record(3); record(4); record(6);
    check("count_sat", int'(notes_recorded), 4);
    check("full_set", int'(full), 1);
    start_play(); wait_end();
    check_log("seq_full", exp_b);

    clear_all();
    record(7); record(2);
    loop_en = 1;
    start_play();
    n = 0;
    while (log_q.size() < 20 && n < 200) begin @(negedge clk); n++; end
    check("loop_bound", int'(log_q.size() >= 20), 1);
    while (log_q.size() > 20) void'(log_q.pop_back());
    check_log("seq_loop", exp_c);
    n = 0;
    while (!step_tick && n < 20) begin @(negedge clk); n++; end
    check("tick_seen", int'(step_tick), 1);
    stop_n = 0;
    @(posedge clk); #2 stop_n = 1;
    @(negedge clk);
    check("stop_ld_play", int'(ld_play), 0);
    check("stop_note_out", int'(note_out), 0);

    loop_en = 0;
    tick();
    start_play(); tick(); tick();
    check("play_running", int'(ld_play), 1);
    #1 rst_n = 0;
    #1;
    check("async_ld_play", int'(ld_play), 0);
    check("async_note_out", int'(note_out), 0);
    check("async_count", int'(notes_recorded), 0);
    check("async_step", int'(step_tick), 0);
    @(posedge clk); #2 rst_n = 1;
    tick();
    check("post_rst_idle", int'(ld_play), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
